// File: rtl/la_capture_buffer_if.sv
// Wishbone slave bus bundle for the logic-analyzer capture buffer.
// The management core drives the master side, and the capture buffer sits on the slave side.
interface la_capture_buffer_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/la_capture_buffer.sv
// Triggered capture of DEPTH consecutive 32-bit LA lane samples, read back over Wishbone.
// Every access is acked one cycle after its hit, and a new hit is accepted only once ack drops.
module la_capture_buffer #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0100,
   parameter int          DEPTH     = 16
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   la_capture_buffer_if.slave        wb,
   input  logic [127:0]              la_data_in,
   output logic                      capture_done_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ARMED   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]    r_state;
   logic [CW-1:0] r_count;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [31:0]   r_mask;
   logic [31:0]   r_value;
   logic [1:0]    r_lane;
   logic [127:0]  r_la_q;
   logic          r_ack;
   logic [31:0]   r_dat;
   logic [31:0]   r_mem [DEPTH];

   logic          w_hit;
   logic [2:0]    w_reg;
   logic          w_wr;
   logic          w_rd;
   logic          w_arm;
   logic          w_clear;
   logic          w_pop;
   logic          w_wen;
   logic [31:0]   w_lane;
   logic          w_match;
   logic [7:0]    w_cnt8;
   logic [31:0]   w_rdata;
   logic          w_unused_adr;

   function automatic logic [31:0] f_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] sel);
      logic [31:0] res;
      for (int i = 0; i < 4; i++)
         res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      return res;
   endfunction

   assign w_hit   = wb.wbs_stb_i & wb.wbs_cyc_i & ~r_ack &
                    (wb.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
   assign w_reg   = wb.wbs_adr_i[4:2];
   assign w_wr    = w_hit & wb.wbs_we_i;
   assign w_rd    = w_hit & ~wb.wbs_we_i;
   assign w_arm   = w_wr & (w_reg == 3'd0) & wb.wbs_sel_i[0] & wb.wbs_dat_i[0];
   assign w_clear = w_wr & (w_reg == 3'd0) & wb.wbs_sel_i[0] & wb.wbs_dat_i[1];
   assign w_pop   = w_rd & (w_reg == 3'd4) & (r_state == S_DONE) & (r_count != '0);
   assign w_unused_adr = ^wb.wbs_adr_i[1:0];

   assign w_lane  = r_la_q[32*r_lane +: 32];
   assign w_match = ((w_lane ^ r_value) & r_mask) == 32'h0;
   // Sample 0 lands on the ARMED->CAPTURE edge, so ARMED writes too.
   assign w_wen   = ~w_clear & (((r_state == S_ARMED) & w_match) | (r_state == S_CAPTURE));

   always_comb begin
      w_cnt8 = '0;
      for (int i = 0; i < CW && i < 8; i++)
         w_cnt8[i] = r_count[i];
   end

   always_comb begin
      w_rdata = '0;
      case (w_reg)
         3'd0:    w_rdata = {28'h0, r_lane, 2'b00};
         3'd1:    w_rdata = r_mask;
         3'd2:    w_rdata = r_value;
         3'd3:    w_rdata = {16'h0, w_cnt8, 6'h0, r_state};
         3'd4:    w_rdata = w_pop ? r_mem[r_rd_ptr] : 32'h0;
         default: w_rdata = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i && w_wen)
         r_mem[r_wr_ptr] <= w_lane;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state  <= S_IDLE;
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_mask   <= '0;
         r_value  <= '0;
         r_lane   <= '0;
         r_la_q   <= '0;
         r_ack    <= 1'b0;
         r_dat    <= '0;
      end else begin
         r_la_q <= la_data_in;
         r_ack  <= w_hit;
         r_dat  <= w_rd ? w_rdata : 32'h0;

         if (w_wr) begin
            case (w_reg)
               3'd0:    if (wb.wbs_sel_i[0]) r_lane <= wb.wbs_dat_i[3:2];
               3'd1:    r_mask  <= f_bytes(r_mask, wb.wbs_dat_i, wb.wbs_sel_i);
               3'd2:    r_value <= f_bytes(r_value, wb.wbs_dat_i, wb.wbs_sel_i);
               default: ;
            endcase
         end

         if (w_clear) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            case (r_state)
               S_IDLE, S_DONE: begin
                  if (w_arm) begin
                     r_state  <= S_ARMED;
                     r_count  <= '0;
                     r_wr_ptr <= '0;
                     r_rd_ptr <= '0;
                  end else if (w_pop) begin
                     r_rd_ptr <= r_rd_ptr + AW'(1);
                     r_count  <= r_count - CW'(1);
                  end
               end
               S_ARMED: begin
                  if (w_match) begin
                     r_state  <= S_CAPTURE;
                     r_wr_ptr <= r_wr_ptr + AW'(1);
                     r_count  <= CW'(1);
                  end
               end
               default: begin
                  r_wr_ptr <= r_wr_ptr + AW'(1);
                  r_count  <= r_count + CW'(1);
                  if (r_count == CW'(DEPTH - 1))
                     r_state <= S_DONE;
               end
            endcase
         end
      end
   end

   assign wb.wbs_ack_o   = r_ack;
   assign wb.wbs_dat_o   = r_dat;
   assign capture_done_o = (r_state == S_DONE);
endmodule

// File: tb/tb_la_capture_buffer.sv
// Directed bench for la_capture_buffer: reset, free-run and masked capture, bus handshake,
// control corner cases and rearm, each scenario checking its own hand-computed results.
module tb_la_capture_buffer;
   localparam logic [31:0] A_CTRL   = 32'h3000_0100;
   localparam logic [31:0] A_MASK   = 32'h3000_0104;
   localparam logic [31:0] A_VALUE  = 32'h3000_0108;
   localparam logic [31:0] A_STATUS = 32'h3000_010C;
   localparam logic [31:0] A_DATA   = 32'h3000_0110;
   localparam logic [31:0] A_UNMAP  = 32'h3000_0114;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] la_data_in;
   logic         capture_done;
   logic         cnt_mode = 1'b0;
   logic [31:0]  cnt = 32'h0000_0100;
   logic [31:0]  la_static = 32'h0;
   int           n_pass = 0;
   int           n_total = 0;

   la_capture_buffer_if bus();

   la_capture_buffer #(.BASE_ADDR(32'h3000_0100), .DEPTH(16)) dut (
      .wb_clk_i       (clk),
      .wb_rst_i       (rst),
      .wb             (bus),
      .la_data_in     (la_data_in),
      .capture_done_o (capture_done)
   );

   always #5 clk = ~clk;
   always @(negedge clk) cnt = cnt + 32'd1;
   assign la_data_in = cnt_mode ? {64'h0, cnt, 32'h0} : {96'h0, la_static};

   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                          input logic [3:0] sel, output logic [31:0] rdat, output logic ack_ok);
      bus.wbs_stb_i = 1'b1;
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = wdat;
      bus.wbs_sel_i = sel;
      @(posedge clk); #1;
      rdat   = bus.wbs_dat_o;
      ack_ok = (bus.wbs_ack_o === 1'b1);
      bus.wbs_stb_i = 1'b0;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      @(posedge clk); #1;
      if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0) ack_ok = 1'b0;
   endtask

   task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat);
      logic [31:0] d;
      logic        a;
      wb_xfer(1'b1, adr, wdat, 4'hF, d, a);
   endtask

   task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
      logic a;
      wb_xfer(1'b0, adr, 32'h0, 4'hF, rdat, a);
   endtask

   task automatic wait_done(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (capture_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic        ok;
      n_total++;
      if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0 || capture_done !== 1'b0)
         $display("FAIL reset_outputs: ack=%b dat=%h done=%b, need 0/0/0",
                  bus.wbs_ack_o, bus.wbs_dat_o, capture_done);
      else n_pass++;
      wb_read(A_STATUS, d);
      n_total++;
      if (d !== 32'h0) $display("FAIL reset_status: got %h need 00000000", d);
      else n_pass++;

      cnt_mode = 1'b1;
      wb_write(A_CTRL, 32'h1);
      bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b0;
      bus.wbs_adr_i = A_STATUS; bus.wbs_sel_i = 4'hF;
      @(posedge clk); #1;
      n_total++;
      if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o[1:0] !== 2'd2)
         $display("FAIL capture_ack_before_rst: ack=%b state=%0d need 1/2",
                  bus.wbs_ack_o, bus.wbs_dat_o[1:0]);
      else n_pass++;
      rst = 1'b1;
      bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
      #1;
      n_total++;
      if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0 || capture_done !== 1'b0)
         $display("FAIL async_rst_capture: ack=%b dat=%h done=%b, need 0/0/0",
                  bus.wbs_ack_o, bus.wbs_dat_o, capture_done);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      wb_read(A_STATUS, d);
      n_total++;
      if (d !== 32'h0) $display("FAIL status_after_rst: got %h need 00000000", d);
      else n_pass++;

      wb_write(A_CTRL, 32'h1);
      wait_done(ok);
      n_total++;
      if (ok !== 1'b1) $display("FAIL done_before_rst: timeout waiting for done");
      else n_pass++;
      rst = 1'b1;
      #1;
      n_total++;
      if (capture_done !== 1'b0) $display("FAIL async_rst_done: done=%b need 0", capture_done);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      cnt_mode = 1'b0;
   endtask

   task automatic test_free_run();
      logic [31:0] d;
      logic [31:0] v0;
      logic        ok;
      cnt_mode = 1'b1;
      wb_write(A_MASK, 32'h0);
      wb_write(A_CTRL, 32'h5);
      wait_done(ok);
      n_total++;
      if (ok !== 1'b1) $display("FAIL free_run_done: timeout waiting for done");
      else n_pass++;
      wb_read(A_STATUS, d);
      n_total++;
      if (d !== 32'h0000_1003) $display("FAIL free_run_status: got %h need 00001003", d);
      else n_pass++;
      wb_read(A_DATA, v0);
      for (int k = 1; k < 16; k++) begin
         wb_read(A_DATA, d);
         n_total++;
         if (d !== v0 + 32'(k))
            $display("FAIL free_run_data[%0d]: got %h need %h", k, d, v0 + 32'(k));
         else n_pass++;
      end
      wb_read(A_DATA, d);
      n_total++;
      if (d !== 32'h0) $display("FAIL free_run_empty_read: got %h need 00000000", d);
      else n_pass++;
      wb_read(A_STATUS, d);
      n_total++;
      if (d !== 32'h0000_0003) $display("FAIL free_run_drained: got %h need 00000003", d);
      else n_pass++;
      cnt_mode = 1'b0;
   endtask

   task automatic test_masked_trigger();
      logic [31:0] d;
      logic        ok;
      la_static = 32'h0;
      wb_write(A_CTRL, 32'h2);
      wb_write(A_CTRL, 32'h0);
      wb_write(A_MASK, 32'h0000_00FF);
      wb_write(A_VALUE, 32'h0000_00A5);
      wb_write(A_CTRL, 32'h1);
      repeat (4) @(posedge clk);
      #1;
      wb_read(A_STATUS, d);
      n_total++;
      if (d !== 32'h0000_0001) $display("FAIL masked_wait_armed: got %h need 00000001", d);
      else n_pass++;
      @(negedge clk) la_static = 32'h1234_56A5;
      @(negedge clk) la_static = 32'h0;
      wait_done(ok);
      n_total++;
      if (ok !== 1'b1) $display("FAIL masked_done: timeout waiting for done");
      else n_pass++;
      for (int k = 0; k < 16; k++) begin
         wb_read(A_DATA, d);
         n_total++;
         if (d !== ((k == 0) ? 32'h1234_56A5 : 32'h0))
            $display("FAIL masked_data[%0d]: got %h need %h", k, d,
                     (k == 0) ? 32'h1234_56A5 : 32'h0);
         else n_pass++;
      end
   endtask

   task automatic test_bus_handshake();
      logic [31:0] d;
      logic        a;
      logic        ok;
      wb_write(A_CTRL, 32'h2);
      wb_xfer(1'b0, A_STATUS, 32'h0, 4'hF, d, a);
      n_total++;
      if (a !== 1'b1 || d[1:0] !== 2'd0) $display("FAIL hs_idle: ack_ok=%b state=%0d need 1/0", a, d[1:0]);
      else n_pass++;
      la_static = 32'h0;
      wb_write(A_MASK, 32'h0000_00FF);
      wb_write(A_VALUE, 32'h0000_00A5);
      wb_write(A_CTRL, 32'h1);
      wb_xfer(1'b0, A_STATUS, 32'h0, 4'hF, d, a);
      n_total++;
      if (a !== 1'b1 || d[1:0] !== 2'd1) $display("FAIL hs_armed: ack_ok=%b state=%0d need 1/1", a, d[1:0]);
      else n_pass++;
      wb_write(A_MASK, 32'h0);
      wb_xfer(1'b0, A_STATUS, 32'h0, 4'hF, d, a);
      n_total++;
      if (a !== 1'b1 || d[1:0] !== 2'd2) $display("FAIL hs_capture: ack_ok=%b state=%0d need 1/2", a, d[1:0]);
      else n_pass++;
      wait_done(ok);
      wb_xfer(1'b0, A_STATUS, 32'h0, 4'hF, d, a);
      n_total++;
      if (a !== 1'b1 || d !== 32'h0000_1003) $display("FAIL hs_done: ack_ok=%b status=%h need 1/00001003", a, d);
      else n_pass++;
      wb_xfer(1'b0, A_UNMAP, 32'h0, 4'hF, d, a);
      n_total++;
      if (a !== 1'b1 || d !== 32'h0) $display("FAIL hs_unmapped: ack_ok=%b data=%h need 1/00000000", a, d);
      else n_pass++;
      wb_write(A_MASK, 32'h1122_3344);
      wb_xfer(1'b1, A_MASK, 32'hAABB_CCDD, 4'b0010, d, a);
      wb_read(A_MASK, d);
      n_total++;
      if (d !== 32'h1122_CC44) $display("FAIL hs_byte_sel: got %h need 1122cc44", d);
      else n_pass++;
   endtask

   task automatic test_ctrl_corners();
      logic [31:0] d;
      logic        ok;
      wb_write(A_CTRL, 32'h3);
      wb_read(A_STATUS, d);
      n_total++;
      if (d !== 32'h0) $display("FAIL clear_wins_over_arm: got %h need 00000000", d);
      else n_pass++;
      wb_write(A_MASK, 32'h0);
      wb_write(A_CTRL, 32'h1);
      wb_write(A_CTRL, 32'h1);
      wb_read(A_STATUS, d);
      n_total++;
      if (d !== 32'h0000_0302) $display("FAIL arm_in_capture: got %h need 00000302", d);
      else n_pass++;
      wait_done(ok);
      wb_read(A_STATUS, d);
      n_total++;
      if (d !== 32'h0000_1003) $display("FAIL arm_in_capture_done: got %h need 00001003", d);
      else n_pass++;
      wb_write(A_MASK, 32'h0000_00FF);
      wb_write(A_CTRL, 32'h1);
      wb_read(A_DATA, d);
      n_total++;
      if (d !== 32'h0) $display("FAIL data_in_armed: got %h need 00000000", d);
      else n_pass++;
      wb_read(A_STATUS, d);
      n_total++;
      if (d !== 32'h0000_0001) $display("FAIL armed_no_pop: got %h need 00000001", d);
      else n_pass++;
   endtask

   task automatic test_rearm();
      logic [31:0] d;
      logic [31:0] v0;
      logic        ok;
      wb_write(A_CTRL, 32'h2);
      cnt_mode = 1'b1;
      wb_write(A_MASK, 32'h0);
      wb_write(A_CTRL, 32'h5);
      wait_done(ok);
      wb_read(A_DATA, v0);
      for (int k = 1; k < 5; k++) begin
         wb_read(A_DATA, d);
         n_total++;
         if (d !== v0 + 32'(k)) $display("FAIL rearm_pop[%0d]: got %h need %h", k, d, v0 + 32'(k));
         else n_pass++;
      end
      wb_read(A_STATUS, d);
      n_total++;
      if (d !== 32'h0000_0B03) $display("FAIL rearm_after_pops: got %h need 00000b03", d);
      else n_pass++;
      cnt_mode = 1'b0;
      la_static = 32'h0;
      wb_write(A_CTRL, 32'h0);
      wb_write(A_MASK, 32'h0000_00FF);
      wb_write(A_VALUE, 32'h0000_00A5);
      wb_write(A_CTRL, 32'h1);
      wb_read(A_STATUS, d);
      n_total++;
      if (d !== 32'h0000_0001) $display("FAIL rearm_status: got %h need 00000001", d);
      else n_pass++;
      @(negedge clk) la_static = 32'hCAFE_00A5;
      @(negedge clk) la_static = 32'h0;
      wait_done(ok);
      wb_read(A_STATUS, d);
      n_total++;
      if (d !== 32'h0000_1003) $display("FAIL rearm_done: got %h need 00001003", d);
      else n_pass++;
      wb_read(A_DATA, d);
      n_total++;
      if (d !== 32'hCAFE_00A5) $display("FAIL rearm_sample0: got %h need cafe00a5", d);
      else n_pass++;
      wb_read(A_DATA, d);
      n_total++;
      if (d !== 32'h0) $display("FAIL rearm_sample1: got %h need 00000000", d);
      else n_pass++;
   endtask

   initial begin
      bus.wbs_stb_i = 1'b0;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_dat_i = 32'h0;
      bus.wbs_adr_i = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_free_run();
      test_masked_trigger();
      test_bus_handshake();
      test_ctrl_corners();
      test_rearm();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
